dm_lsu: RTL and testbench

Load/store unit directly upstream of the word-wide data memory `dm`. It accepts one byte, halfword or word request at a time over a valid/ready handshake and converts it into `dm` word accesses. `dm` has a synchronous write on the clk posedge and a combinational read. Sub-word stores are performed as read-modify-write. Loads return sign- or zero-extended data; misaligned or out-of-range requests are rejected without touching memory.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/dm_lsu_if.sv | 47 ++++
 rtl/lsu_lane.sv | 49 ++++
 rtl/dm_lsu.sv | 132 +++++++++++++
 tb/tb_dm_lsu.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the dm_lsu load/store unit.
// Size codes, FSM encodings and the default dm depth.
package lsu_pkg;

    localparam int DM_WORDS_DEF = 1024;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_ACCESS   = 2'b01,
        S_MERGE_WR = 2'b10,
        S_RESP     = 2'b11
    } state_e;

endpackage

// File: rtl/dm_lsu_if.sv
// Request/response channel between core and LSU,
// and the word bus between LSU and dm.
interface lsu_req_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;

    modport master (
        output req_valid, req_write, req_size,
        output req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size,
        input  req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

interface dm_bus_if #(
    parameter int ADDR_W = 32
);
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    modport master (
        output dm_we, dm_addr, dm_din,
        input  dm_dout
    );

    modport slave (
        input  dm_we, dm_addr, dm_din,
        output dm_dout
    );
endinterface

// File: rtl/lsu_lane.sv
// Lane extract/extend for loads and lane merge for
// sub-word stores, little-endian.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] merge_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_o,
    output logic [31:0] st_o
);

    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;

    assign sh = {lane_i, 3'b000};
    assign b  = 8'(rdata_i >> sh);
    assign h  = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        ld_o = rdata_i;
        case (size_i)
            SZ_BYTE: ld_o = {{24{signed_i & b[7]}}, b};
            SZ_HALF: ld_o = {{16{signed_i & h[15]}}, h};
            default: ld_o = rdata_i;
        endcase
    end

    always_comb begin
        st_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                st_o = merge_i;
                st_o[sh +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                st_o = merge_i;
                if (lane_i[1]) st_o[31:16] = wdata_i[15:0];
                else           st_o[15:0]  = wdata_i[15:0];
            end
            default: st_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit in front of word-wide dm: one request
// at a time, sub-word stores done as read-modify-write.
module dm_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DM_WORDS = DM_WORDS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    lsu_req_if.slave   req,
    dm_bus_if.master   dm
);

    localparam logic [ADDR_W-1:0] WORDS_L = ADDR_W'(DM_WORDS);

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              req_err;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       ld_data;
    logic [31:0]       st_data;

    // Error is resolved at accept time so ACCESS never drives dm_we for it
    assign req_err =
        (req.req_size == SZ_ILL) |
        ((req.req_size == SZ_HALF) & req.req_addr[0]) |
        ((req.req_size == SZ_WORD) & (req.req_addr[1:0] != 2'b00)) |
        ({2'b00, req.req_addr[ADDR_W-1:2]} >= WORDS_L);

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_lane u_lane (
        .lane_i   (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (sgn_q),
        .rdata_i  (dm.dm_dout),
        .merge_i  (merge_q),
        .wdata_i  (wdata_q),
        .ld_o     (ld_data),
        .st_o     (st_data)
    );

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        dm.dm_we   = 1'b0;
        dm.dm_addr = '0;
        dm.dm_din  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    wr_d    = req.req_write;
                    size_d  = req.req_size;
                    sgn_d   = req.req_signed;
                    addr_d  = req.req_addr;
                    wdata_d = req.req_wdata;
                    err_d   = req_err;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                dm.dm_addr = word_addr;
                state_d    = S_RESP;
                if (err_q) begin
                    state_d = S_RESP;
                end else if (!wr_q) begin
                    rdata_d = ld_data;
                end else if (size_q == SZ_WORD) begin
                    dm.dm_we  = 1'b1;
                    dm.dm_din = wdata_q;
                end else begin
                    merge_d = dm.dm_dout;
                    state_d = S_MERGE_WR;
                end
            end
            S_MERGE_WR: begin
                dm.dm_we   = 1'b1;
                dm.dm_addr = word_addr;
                dm.dm_din  = st_data;
                state_d    = S_RESP;
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
        end
    end

    assign req.req_ready = (state_q == S_IDLE);
    assign req.rsp_valid = (state_q == S_RESP);
    assign req.rsp_err   = (state_q == S_RESP) & err_q;
    assign req.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu against a behavioural word memory.
module tb_dm_lsu;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   we_cnt = 0;
    int   rsp_cnt = 0;

    logic [31:0] mem [1024];

    lsu_req_if #(.ADDR_W(32)) rq ();
    dm_bus_if  #(.ADDR_W(32)) db ();

    dm_lsu #(.ADDR_W(32), .DM_WORDS(1024)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (rq),
        .dm    (db)
    );

    always #5 clk = ~clk;

    assign db.dm_dout = mem[db.dm_addr[11:2]];

    always @(posedge clk) begin
        if (db.dm_we) begin
            mem[db.dm_addr[11:2]] <= db.dm_din;
            we_cnt <= we_cnt + 1;
        end
        if (rq.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, output logic e,
                          output int lat, output logic [31:0] wdin);
        @(negedge clk);
        rq.req_valid  = 1'b1;
        rq.req_write  = w;
        rq.req_size   = sz;
        rq.req_signed = sg;
        rq.req_addr   = a;
        rq.req_wdata  = wd;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        lat  = 0;
        e    = 1'b0;
        wdin = 32'h0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (db.dm_we) wdin = db.dm_din;
            if (rq.rsp_valid) begin
                lat = n;
                e   = rq.rsp_err;
                break;
            end
        end
    endtask

    logic        e;
    int          lat;
    logic [31:0] wdin;
    int          w0;
    int          r0;
    int          rdy;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset         = 1'b1;
        rq.req_valid  = 1'b0;
        rq.req_write  = 1'b0;
        rq.req_size   = 2'b00;
        rq.req_signed = 1'b0;
        rq.req_addr   = 32'h0;
        rq.req_wdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(rq.req_ready), 32'd1);
        chk("rst_rspv", 32'(rq.rsp_valid), 32'd0);
        chk("rst_we", 32'(db.dm_we), 32'd0);
        chk("rst_addr", db.dm_addr, 32'h0);
        chk("rst_din", db.dm_din, 32'h0);
        chk("rst_rdata", rq.rsp_rdata, 32'h0);
        reset = 1'b0;

        w0 = we_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678, e, lat, wdin);
        chk("sw_err", 32'(e), 32'd0);
        chk("sw_lat", 32'(lat), 32'd2);
        #1 chk("sw_we_cnt", 32'(we_cnt - w0), 32'd1);
        chk("sw_mem", mem[0], 32'h12345678);

        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, e, lat, wdin);
        chk("lw_err", 32'(e), 32'd0);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_data", rq.rsp_rdata, 32'h12345678);

        w0 = we_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h2, 32'h000000AB, e, lat, wdin);
        chk("sb_din", wdin, 32'h12AB5678);
        chk("sb_lat", 32'(lat), 32'd3);
        #1 chk("sb_we_cnt", 32'(we_cnt - w0), 32'd1);
        chk("sb_mem", mem[0], 32'h12AB5678);

        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h87654321, e, lat, wdin);
        do_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, e, lat, wdin);
        chk("lb_s7", rq.rsp_rdata, 32'hFFFFFF87);
        do_req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, e, lat, wdin);
        chk("lbu_7", rq.rsp_rdata, 32'h00000087);
        do_req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, e, lat, wdin);
        chk("lbu_5", rq.rsp_rdata, 32'h00000043);
        do_req(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, e, lat, wdin);
        chk("lh_s4", rq.rsp_rdata, 32'h00004321);
        do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, e, lat, wdin);
        chk("lh_s6", rq.rsp_rdata, 32'hFFFF8765);
        do_req(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, e, lat, wdin);
        chk("lhu_6", rq.rsp_rdata, 32'h00008765);

        w0 = we_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h2, 32'hDEADBEEF, e, lat, wdin);
        chk("mis_sw_err", 32'(e), 32'd1);
        chk("mis_sw_lat", 32'(lat), 32'd2);
        #1 chk("mis_sw_we", 32'(we_cnt - w0), 32'd0);
        chk("mis_sw_mem", mem[0], 32'h12AB5678);
        do_req(1'b0, 2'b01, 1'b1, 32'h1, 32'h0, e, lat, wdin);
        chk("mis_lh_err", 32'(e), 32'd1);
        chk("mis_lh_keep", rq.rsp_rdata, 32'h00008765);
        do_req(1'b0, 2'b10, 1'b0, 32'd4096, 32'h0, e, lat, wdin);
        chk("oor_err", 32'(e), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'd4092, 32'h0, e, lat, wdin);
        chk("top_ok", 32'(e), 32'd0);
        do_req(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, e, lat, wdin);
        chk("sz11_err", 32'(e), 32'd1);
        #1 chk("err_we", 32'(we_cnt - w0), 32'd0);

        do_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000BEEF, e, lat, wdin);
        chk("sh_din", wdin, 32'hBEEF4321);
        chk("sh_lat", 32'(lat), 32'd3);

        w0  = we_cnt;
        rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rq.req_valid  = 1'b1;
            rq.req_write  = 1'b1;
            rq.req_size   = 2'b10;
            rq.req_addr   = 32'h100 + 32'(4 * i);
            rq.req_wdata  = 32'hA0 + 32'(i);
            if (rq.req_ready) rdy++;
        end
        @(negedge clk);
        rq.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("hs_ready", 32'(rdy), 32'd4);
        chk("hs_we_cnt", 32'(we_cnt - w0), 32'd4);
        chk("hs_m64", mem[64], 32'hA0);
        chk("hs_m65", mem[65], 32'h0);
        chk("hs_m66", mem[66], 32'h0);
        chk("hs_m67", mem[67], 32'hA3);
        chk("hs_m68", mem[68], 32'h0);
        chk("hs_m70", mem[70], 32'hA6);
        chk("hs_m73", mem[73], 32'hA9);

        @(negedge clk);
        rq.req_valid  = 1'b1;
        rq.req_write  = 1'b1;
        rq.req_size   = 2'b00;
        rq.req_signed = 1'b0;
        rq.req_addr   = 32'h4;
        rq.req_wdata  = 32'h55;
        @(posedge clk);
        #1 rq.req_valid = 1'b0;
        @(posedge clk);
        #1 chk("mw_we", 32'(db.dm_we), 32'd1);
        r0    = rsp_cnt;
        reset = 1'b1;
        #1 chk("rst_mw_we", 32'(db.dm_we), 32'd0);
        chk("rst_mw_din", db.dm_din, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        chk("rst_mem", mem[1], 32'hBEEF4321);
        chk("rst_ready2", 32'(rq.req_ready), 32'd1);
        chk("rst_rdata2", rq.rsp_rdata, 32'h0);

        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, e, lat, wdin);
        chk("post_lw", rq.rsp_rdata, 32'hBEEF4321);
        chk("post_lat", 32'(lat), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
